// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states
// and divide-by-zero constants.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0100;
  localparam logic [OP_W-1:0] OP_SLT   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLTU  = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLL   = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRL   = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA   = 4'b1001;
  localparam logic [OP_W-1:0] OP_RSV0  = 4'b1010;
  localparam logic [OP_W-1:0] OP_RSV1  = 4'b1011;
  localparam logic [OP_W-1:0] OP_MUL   = 4'b1100;
  localparam logic [OP_W-1:0] OP_MULHU = 4'b1101;
  localparam logic [OP_W-1:0] OP_DIVU  = 4'b1110;
  localparam logic [OP_W-1:0] OP_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  // divu by zero fills the quotient with this bit; remu by zero returns the dividend
  localparam logic DIVZ_QUOT_FILL      = 1'b1;
  localparam logic DIVZ_REM_IS_DIVIDEND = 1'b1;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between execute-stage control and alu_mc.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             OutValid;
  logic             OutReady;

  modport master (
    output InValid, a, b, ALUControl, OutReady,
    input  InReady, ALUResult, Zero, OutValid
  );

  modport slave (
    input  InValid, a, b, ALUControl, OutReady,
    output InReady, ALUResult, Zero, OutValid
  );
endinterface

// File: rtl/alu_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle over WIDTH cycles.
// Quotient/remainder outputs carry the value produced by the final iteration.
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_c_o,
  output logic [WIDTH-1:0] quotient_c_o,
  output logic [WIDTH-1:0] remainder_c_o
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   rem_shift_c;
  logic [WIDTH:0]   trial_c;
  logic [WIDTH:0]   rem_nx_c;
  logic [WIDTH-1:0] quo_nx_c;

  // One restoring step; trial MSB set means the subtraction went negative
  always_comb begin
    rem_shift_c = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial_c     = rem_shift_c - {1'b0, dvs_q};
    if (!trial_c[WIDTH]) begin
      rem_nx_c = trial_c;
      quo_nx_c = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx_c = rem_shift_c;
      quo_nx_c = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done_c_o      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient_c_o  = (dvs_q == '0) ? {WIDTH{DIVZ_QUOT_FILL}} : quo_nx_c;
  assign remainder_c_o = rem_nx_c[WIDTH-1:0];

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_nx_c;
      quo_d = quo_nx_c;
      cnt_d = cnt_q + CNT_W'(1);
      if (done_c_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I ALU: single-cycle logic/arith ops plus iterative mul/mulhu
// and, when ALU_MC_DIV_EN is defined, iterative divu/remu.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic    clk,
  input  logic    reset_n,
  alu_mc_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  alu_state_e       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   mul_sum_c;
  logic [ACC_W-1:0] acc_step_c;
  logic             is_mul_c;
  logic             is_div_c;

  function automatic logic [WIDTH-1:0] alu_single(input logic [OP_W-1:0]  op,
                                                   input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y);
    logic [CNT_W-1:0] sh;
    logic [WIDTH-1:0] r;
    sh = y[CNT_W-1:0];
    case (op)
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_SLL:  r = x << sh;
      OP_SRL:  r = x >> sh;
      OP_SRA:  r = $unsigned($signed(x) >>> sh);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Shift-add step: conditionally add the multiplicand into the high half, then shift right
  assign mul_sum_c  = {1'b0, acc_q[ACC_W-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
  assign acc_step_c = {mul_sum_c, acc_q[WIDTH-1:1]};

  assign is_mul_c = (bus.ALUControl == OP_MUL) || (bus.ALUControl == OP_MULHU);

`ifdef ALU_MC_DIV_EN
  logic             div_start_c;
  logic             div_done_c;
  logic [WIDTH-1:0] div_quot_c;
  logic [WIDTH-1:0] div_rem_c;

  assign is_div_c    = (bus.ALUControl == OP_DIVU) || (bus.ALUControl == OP_REMU);
  assign div_start_c = (state_q == IDLE) && bus.InValid && is_div_c;

  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (div_start_c),
    .dividend_i    (bus.a),
    .divisor_i     (bus.b),
    .done_c_o      (div_done_c),
    .quotient_c_o  (div_quot_c),
    .remainder_c_o (div_rem_c)
  );
`else
  assign is_div_c = 1'b0;
`endif

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          op_d = bus.ALUControl;
          if (is_mul_c) begin
            mcand_d = bus.a;
            acc_d   = {WIDTH'(0), bus.b};
            cnt_d   = '0;
            state_d = MUL;
          end else if (is_div_c) begin
            state_d = DIV;
          end else begin
            result_d = alu_single(bus.ALUControl, bus.a, bus.b);
            state_d  = DONE;
          end
        end
      end
      MUL: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = (op_q == OP_MULHU) ? acc_step_c[ACC_W-1:WIDTH] : acc_step_c[WIDTH-1:0];
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DIV: begin
`ifdef ALU_MC_DIV_EN
        if (div_done_c) begin
          result_d = (op_q == OP_REMU) ? div_rem_c : div_quot_c;
          state_d  = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        if (bus.OutReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    zero_d      = (result_d == '0);
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.InReady   = in_ready_q;
  assign bus.ALUResult = result_q;
  assign bus.Zero      = zero_q;
  assign bus.OutValid  = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases, backpressure, mid-op reset
// and randomized operations against a plain-arithmetic reference model.
module tb_alu_mc;
  localparam int unsigned W = 32;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint unsigned prod;
    logic [31:0]     r;
    prod = longint'(x) * longint'(y);
    case (op)
      4'd0:  r = x + y;
      4'd1:  r = x - y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:  r = (x < y) ? 32'd1 : 32'd0;
      4'd7:  r = x << y[4:0];
      4'd8:  r = x >> y[4:0];
      4'd9:  r = $unsigned($signed(x) >>> y[4:0]);
      4'd12: r = prod[31:0];
      4'd13: r = prod[63:32];
`ifdef ALU_MC_DIV_EN
      4'd14: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      4'd15: r = (y == 0) ? x : x % y;
`endif
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_latency(input logic [3:0] op);
    if (op == 4'd12 || op == 4'd13) return W + 1;
`ifdef ALU_MC_DIV_EN
    if (op == 4'd14 || op == 4'd15) return W + 1;
`endif
    return 1;
  endfunction

  // Issue one op, measure latency, check result, optionally stall the handoff
  task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int hold);
    logic [31:0] exp_r;
    int          lat;
    exp_r = model(op, x, y);
    @(negedge clk);
    check_eq("in_ready_before", 64'(bus.InReady), 64'(1));
    bus.InValid    = 1'b1;
    bus.a          = x;
    bus.b          = y;
    bus.ALUControl = op;
    bus.OutReady   = (hold == 0);
    @(posedge clk);
    #1;
    bus.InValid    = 1'b0;
    bus.a          = $urandom;
    bus.b          = $urandom;
    bus.ALUControl = 4'($urandom);
    lat = 1;
    while (!bus.OutValid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq($sformatf("latency op%0d", op), 64'(lat), 64'(model_latency(op)));
    check_eq($sformatf("result op%0d", op), 64'(bus.ALUResult), 64'(exp_r));
    check_eq($sformatf("zero op%0d", op), 64'(bus.Zero), 64'(exp_r == 32'd0));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.a       = $urandom;
      bus.b       = $urandom;
      bus.InValid = 1'($urandom);
      @(posedge clk);
      #1;
      check_eq("hold_result", 64'(bus.ALUResult), 64'(exp_r));
      check_eq("hold_in_ready", 64'(bus.InReady), 64'(0));
      check_eq("hold_out_valid", 64'(bus.OutValid), 64'(1));
    end
    @(negedge clk);
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b1;
    @(posedge clk);
    #1;
    check_eq("handoff_out_valid", 64'(bus.OutValid), 64'(0));
    check_eq("handoff_in_ready", 64'(bus.InReady), 64'(1));
  endtask

  initial begin
    logic [3:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    total          = 0;
    bad            = 0;
    bus.InValid    = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.ALUControl = '0;
    bus.OutReady   = 1'b1;
    reset_n        = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_result", 64'(bus.ALUResult), 64'(0));
    check_eq("rst_zero", 64'(bus.Zero), 64'(1));
    check_eq("rst_out_valid", 64'(bus.OutValid), 64'(0));
    check_eq("rst_in_ready", 64'(bus.InReady), 64'(1));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run_op(4'd0, 32'd5, 32'd7, 0);
    run_op(4'd1, 32'd9, 32'd9, 0);
    run_op(4'd9, 32'h8000_0000, 32'h24, 0);
    run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(4'd12, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(4'd13, 32'hFFFF_FFFF, 32'd2, 0);
    run_op(4'd14, 32'd100, 32'd0, 0);
    run_op(4'd15, 32'd100, 32'd0, 0);
    run_op(4'd14, 32'd100, 32'd7, 0);
    run_op(4'd15, 32'd100, 32'd7, 0);
    run_op(4'd10, 32'h1234, 32'h5678, 0);
    run_op(4'd0, 32'd3, 32'd4, 5);
    run_op(4'd13, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5);

    // Reset ten cycles into a multiply
    @(negedge clk);
    bus.InValid    = 1'b1;
    bus.a          = 32'h1234_5678;
    bus.b          = 32'h9ABC_DEF0;
    bus.ALUControl = 4'd12;
    @(posedge clk);
    #1 bus.InValid = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_eq("abort_out_valid", 64'(bus.OutValid), 64'(0));
    check_eq("abort_result", 64'(bus.ALUResult), 64'(0));
    check_eq("abort_zero", 64'(bus.Zero), 64'(1));
    check_eq("abort_in_ready", 64'(bus.InReady), 64'(1));
    @(negedge clk);
    reset_n = 1'b1;
    run_op(4'd0, 32'd1, 32'd1, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 40));
        default: rb = 32'($urandom);
      endcase
      run_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
